// File: rtl/dmem_pkg.sv
// Shared constants for the multi-cycle data-memory responder.
// State encoding, default geometry and latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_ACK  = 2'd2
  } dm_state_e;

  localparam int DM_DEPTH_DEF   = 1024;
  localparam int DM_LATENCY_DEF = 4;
  localparam int DM_CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with a synchronous write port and a read register.
// The read register is the responder's data_o and clears on reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] memory [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = memory[idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Contents are not reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i && en_i && we_i) begin
      memory[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder with fixed access latency and req/ack handshake.
// busy_o is a pure state decode so the pipeline stall has no path from req_i.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DM_DEPTH_DEF,
  parameter int LATENCY = DM_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DM_CNT_W-1:0] CNT_INIT = DM_CNT_W'(LATENCY - 1);
  localparam logic [DM_CNT_W-1:0] CNT_ONE  = DM_CNT_W'(1);

  dm_state_e state_q;
  dm_state_e state_d;

  logic [DM_CNT_W-1:0] cnt_q;
  logic [DM_CNT_W-1:0] cnt_d;
  logic                we_q;
  logic                we_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic [31:0]         wdata_q;
  logic [31:0]         wdata_d;
  logic                acc_en;
  logic                unused_addr;

  assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      DM_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[IDX_W+1:2];
          wdata_d = data_i;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? DM_ACK : DM_WAIT;
        end
      end
      DM_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DM_ACK;
        end
      end
      DM_ACK: begin
        state_d = DM_IDLE;
      end
      default: begin
        state_d = DM_IDLE;
      end
    endcase
  end

  // The access fires on the edge entering ACK, using the *_d bundle so that
  // a LATENCY of 1 sees the request fields straight from the ports.
  assign acc_en = (state_d == DM_ACK) && (state_q != DM_ACK);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (acc_en),
    .we_i    (we_d),
    .idx_i   (idx_d),
    .wdata_i (wdata_d),
    .rdata_o (data_o)
  );

  assign ack_o  = (state_q == DM_ACK);
  assign busy_o = (state_q != DM_IDLE);

endmodule
